// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions the raw board push-buttons that drive the SLC-3 Run/Continue
// inputs. Each channel is handled on its own:
//   1. A SYNC_STAGES-deep flip-flop synchronizer brings the asynchronous
//      active-low button into the Clk domain.
//   2. A four-state debounce FSM commits a new level only after it has been
//      seen for DEBOUNCE_CYCLES consecutive synchronized samples.
//   3. Registered outputs give the committed level and one-cycle press and
//      release pulses.
//
// Optional feature (compile-time macro BTN_AUTO_REPEAT_EN):
//   When defined, a held button emits another btn_press pulse every
//   REPEAT_CYCLES cycles after the initial press pulse. When undefined there
//   is no repeat logic and each committed press gives exactly one pulse.
//
// Ports
//   Clk          in   1        system clock (50 MHz on the board)
//   Reset        in   1        synchronous, active-high reset
//   btn_n_raw    in   NUM_BTN  raw asynchronous buttons, 0 = pressed
//   btn_level    out  NUM_BTN  debounced state, 1 = pressed
//   btn_level_n  out  NUM_BTN  ~btn_level, drives the active-low slc3 inputs
//   btn_press    out  NUM_BTN  one-cycle pulse on a committed press
//   btn_release  out  NUM_BTN  one-cycle pulse on a committed release
//
// Debug visibility: the per-channel FSM state is held in state_q[] (type
// btn_state_e) and the debounce counters in cnt_q[]; both are plain module
// level registers so checkers can bind to them directly.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] btn_n_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_level_n,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // ---------------------------------------------------------------------------
  // Parameter sanity checks (elaboration time only)
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_CHK_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_CHK_RELEASE = 2'd3
  } btn_state_e;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The CHK states are entered with cnt=1, so reaching DEBOUNCE_CYCLES-1
  // means the new level has been seen on DEBOUNCE_CYCLES consecutive samples
  // (the entering sample plus the ones counted in the CHK state).
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q  [NUM_BTN];
  btn_state_e             state_q [NUM_BTN];
  btn_state_e             state_d [NUM_BTN];
  logic [CW-1:0]          cnt_q   [NUM_BTN];
  logic [CW-1:0]          cnt_d   [NUM_BTN];
`ifdef BTN_AUTO_REPEAT_EN
  logic [RW-1:0]          rpt_q   [NUM_BTN];
  logic [RW-1:0]          rpt_d   [NUM_BTN];
`endif

  logic [NUM_BTN-1:0] s;          // synchronized, inverted: 1 = pressed
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] release_d;
  logic [NUM_BTN-1:0] level_d;

  // Last synchronizer stage, inverted so the FSM works in "1 = pressed".
  always_comb begin
    s = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      s[i] = ~sync_q[i][SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    press_d   = '0;
    release_d = '0;
    level_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTO_REPEAT_EN
      rpt_d[i]   = rpt_q[i];
`endif

      case (state_q[i])
        ST_RELEASED: begin
          if (s[i]) begin
            state_d[i] = ST_CHK_PRESS;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = '0;
          end
        end

        ST_CHK_PRESS: begin
          if (!s[i]) begin
            // Bounce: level went back before it was stable long enough.
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end

        ST_PRESSED: begin
          if (!s[i]) begin
            state_d[i] = ST_CHK_RELEASE;
            cnt_d[i]   = CNT_ONE;
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            // Repeat counter only advances while the press is stable.
            if (rpt_q[i] >= RPT_LAST) begin
              rpt_d[i]   = '0;
              press_d[i] = 1'b1;
            end else begin
              rpt_d[i]   = rpt_q[i] + RPT_ONE;
            end
`endif
          end
        end

        ST_CHK_RELEASE: begin
          // The repeat counter is left untouched here so a release bounce
          // resumes the repeat cadence where it stopped.
          if (s[i]) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= CNT_LAST) begin
            state_d[i]   = ST_RELEASED;
            cnt_d[i]     = '0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i]     = cnt_q[i] + CNT_ONE;
          end
        end

        default: begin
          state_d[i] = ST_RELEASED;
          cnt_d[i]   = '0;
        end
      endcase

`ifdef BTN_AUTO_REPEAT_EN
      // Once the press is committed away, the next press starts a fresh
      // repeat period.
      if ((state_d[i] == ST_RELEASED) || (state_d[i] == ST_CHK_PRESS)) begin
        rpt_d[i] = '0;
      end
`endif

      // Level tracks the committed side of the FSM; registering it from the
      // next state aligns its change with the pulse cycle.
      level_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_CHK_RELEASE);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        // Preset to the released level so no false press follows reset.
        sync_q[i]  <= '1;
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
      btn_level   <= '0;
      btn_level_n <= '1;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], btn_n_raw[i]};
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef BTN_AUTO_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
      btn_level   <= level_d;
      btn_level_n <= ~level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8, NUM_BTN=2. One vector = one clock edge: inputs are driven
// after the falling edge, outputs are sampled 1 time unit after the next
// rising edge ("edge k" of a run). Expected latency from the first edge that
// samples a new stable level to the pulse is SYNC_STAGES+DEBOUNCE_CYCLES = 6.
// Works with and without BTN_AUTO_REPEAT_EN defined.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NUM_BTN = 2;
  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int REP     = 8;
  localparam int LAT     = SYNC + DEB;
  localparam int W       = 4 * NUM_BTN;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_BTN-1:0] btn_n_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_level_n;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN        (NUM_BTN),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .Clk        (clk),
    .Reset      (reset),
    .btn_n_raw  (btn_n_raw),
    .btn_level  (btn_level),
    .btn_level_n(btn_level_n),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic check_outputs(input string tag, input int k);
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    exp_v = exp_q.pop_front();
    got_v = {btn_level, btn_level_n, btn_press, btn_release};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s edge %0d: got level=%b level_n=%b press=%b release=%b, expected level=%b level_n=%b press=%b release=%b",
               tag, k, got_v[7:6], got_v[5:4], got_v[3:2], got_v[1:0],
               exp_v[7:6], exp_v[5:4], exp_v[3:2], exp_v[1:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic apply(input logic rst, input logic [1:0] raw,
                       input logic [1:0] lvl, input logic [1:0] prs,
                       input logic [1:0] rel, input string tag, input int k);
    reset     = rst;
    btn_n_raw = raw;
    exp_q.push_back({lvl, ~lvl, prs, rel});
    @(posedge clk);
    #1;
    check_outputs(tag, k);
    @(negedge clk);
  endtask

  // Press pulse expected at edge k of a held press.
  function automatic bit press_due(input int k);
    bit due;
    due = (k == LAT);
`ifdef BTN_AUTO_REPEAT_EN
    if (k > LAT && ((k - LAT) % REP) == 0) due = 1'b1;
`endif
    return due;
  endfunction

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [1:0] raw;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    string      tag;
    int         k;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] cur_lvl;

  task automatic add_vec(input logic rst, input logic [1:0] raw,
                         input logic [1:0] lvl, input logic [1:0] prs,
                         input logic [1:0] rel, input string tag, input int k);
    vec_t v;
    v.rst = rst; v.raw = raw; v.level = lvl; v.press = prs; v.rel = rel;
    v.tag = tag; v.k = k;
    vecs.push_back(v);
  endtask

  // A run of n edges with a constant raw level after a change (n >= LAT).
  task automatic add_run(input string tag, input logic [1:0] raw, input int n);
    logic [1:0] new_lvl;
    logic [1:0] chg;
    new_lvl = ~raw;
    chg     = new_lvl ^ cur_lvl;
    for (int k = 1; k <= n; k++) begin
      add_vec(1'b0, raw,
              (k >= LAT) ? new_lvl : cur_lvl,
              press_due(k) ? (chg & new_lvl) : 2'b00,
              (k == LAT) ? (chg & ~new_lvl) : 2'b00,
              tag, k);
    end
    cur_lvl = new_lvl;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] bounce_pat;
    reset     = 1'b1;
    btn_n_raw = 2'b11;
    cur_lvl   = 2'b00;
    bounce_pat = 3'b100;  // raw[0] per edge: 0, 0, 1 (bit index = position)

    // Reset with buttons released.
    for (int k = 1; k <= 3; k++) add_vec(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, "reset", k);
    // Single press on channel 0, then its release.
    add_run("press0", 2'b10, 20);
    add_run("release0", 2'b11, 10);
    // Bouncing press: 0,0,1 five times, never stable for 4 samples.
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 3; p++) begin
        add_vec(1'b0, {1'b1, bounce_pat[p]}, cur_lvl, 2'b00, 2'b00, "bounce", r * 3 + p + 1);
      end
    end
    add_run("bounce_settle", 2'b10, 10);
    add_run("bounce_release", 2'b11, 10);
    // Both channels on the same edge.
    add_run("press_both", 2'b00, 10);
    add_run("release_both", 2'b11, 10);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].raw, vecs[i].level, vecs[i].press,
            vecs[i].rel, vecs[i].tag, vecs[i].k);
    end

    // Reset at edge 3 of a press, button let go during reset: no pulse.
    apply(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "abort_pre", 1);
    apply(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "abort_pre", 2);
    apply(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, "abort_rst", 3);
    apply(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, "abort_rst", 4);
    for (int k = 1; k <= 8; k++) apply(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, "abort_after", k);

    // Reset at edge 3 of a press with the button held through reset:
    // no pulse during reset, fresh press 6 edges after reset drops.
    apply(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "held_pre", 1);
    apply(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, "held_pre", 2);
    for (int k = 3; k <= 5; k++) apply(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, "held_rst", k);
    for (int k = 1; k <= 10; k++) begin
      apply(1'b0, 2'b10, (k >= LAT) ? 2'b01 : 2'b00,
            press_due(k) ? 2'b01 : 2'b00, 2'b00, "held_thru_reset", k);
    end
    for (int k = 1; k <= 10; k++) begin
      apply(1'b0, 2'b11, (k < LAT) ? 2'b01 : 2'b00, 2'b00,
            (k == LAT) ? 2'b01 : 2'b00, "held_release", k);
    end

    // Long hold: one pulse at edge 6, plus repeats at 14, 22, 30 when the
    // auto-repeat build is used.
    for (int k = 1; k <= 31; k++) begin
      apply(1'b0, 2'b10, (k >= LAT) ? 2'b01 : 2'b00,
            press_due(k) ? 2'b01 : 2'b00, 2'b00, "hold31", k);
    end
    for (int k = 1; k <= 10; k++) begin
      apply(1'b0, 2'b11, (k < LAT) ? 2'b01 : 2'b00, 2'b00,
            (k == LAT) ? 2'b01 : 2'b00, "hold31_release", k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
